acp_slave_interface: RTL and testbench
======================================

# acp_slave_interface

- Parametrised ACP bus slave port, successor to the fixed write-only peripheral slave FSM.
- Adds read and write transactions, upper-address decode against a base address, a programmable wait-state count and incrementing bursts of up to 2^BURST_BITS beats.
- Sits between the ACP bus (`bus_in`/`bus_out`/`ack`/`ctrl_in`) and a peripheral's local register or memory port.
- With `WAIT_CYCLES=1` and single-beat writes, its cycle behaviour matches the previous generation exactly.

## Interface

**Parameters**
- `BUS_WIDTH`, 32: bus data/address width.
- `CTRL_WIDTH`, 8: control field width; must be ≥ `2+BURST_BITS`.
- `ADDR_WIDTH`, 16: local offset width; `bus_in[ADDR_WIDTH-1:0]`.
- `BASE_ADDR`, 16'h0001: width `BUS_WIDTH-ADDR_WIDTH`; compared against `bus_in[BUS_WIDTH-1:ADDR_WIDTH]`.
- `WAIT_CYCLES`, 1: wait states before each data beat; 0 is legal.
- `BURST_BITS`, 2: width of the burst-length field.

**Ports**
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bus_in`  in  `BUS_WIDTH`  address in the request cycle; write data in write DATA cycles.
- `ctrl_in`  in  `CTRL_WIDTH`  `[1]` = we; `[2+:BURST_BITS]` = beats−1; other bits ignored.
- `ack`  in  1  master request; held high for the whole transaction.
- `bus_out`  out  `BUS_WIDTH`  read data, registered.
- `bus_oe`  out  1  slave drives `bus_out`.
- `rdy`  out  1  beat strobe toward the master.
- `local_addr`  out  `ADDR_WIDTH`  current beat offset, registered.
- `local_wdata`  out  `BUS_WIDTH`  equals `bus_in`, valid when `data_we`=1.
- `data_we`  out  1  local write strobe, one cycle per beat.
- `data_re`  out  1  local read strobe, one cycle per beat.
- `local_rdata`  in  `BUS_WIDTH`  combinational read data, valid in the same cycle as `data_re`.

## Operation

**States:** IDLE, IGNORE, WAIT, DATA, FINISH.

- **IDLE**, `ack`=1:
  - Upper bits match `BASE_ADDR`:
    - latch `we`, beats−1 and the offset into `local_addr`;
    - load the wait counter with `WAIT_CYCLES`;
    - go to WAIT, or straight to DATA if `WAIT_CYCLES`=0.
  - No match: go to IGNORE.
- **IGNORE**: no outputs asserted; return to IDLE only when `ack`=0. A held `ack` never re-decodes.
- **WAIT**: decrement the counter; go to DATA when it reaches 0 after `WAIT_CYCLES` cycles.
- **DATA**:
  - write: `data_we`=`rdy`=1;
  - read: `data_re`=1, and `local_rdata` is captured into `bus_out` at the end of the cycle.
  - Beats remaining: `local_addr` += 1, wrapping modulo 2^`ADDR_WIDTH`; decrement the beat count; reload the wait counter; go to WAIT, or DATA if `WAIT_CYCLES`=0.
  - Last beat: go to FINISH.
- **FINISH**: hold while `ack`=1; go to IDLE when `ack`=0.
- **`bus_oe`**: set on the edge ending the first read DATA; held through FINISH; cleared on entry to IDLE. Never set for writes.
- **`rdy` for reads**: high for exactly one cycle after each read DATA cycle, i.e. the cycle in which the new `bus_out` is first visible.
- **Abort**: `ack`=0 in WAIT or DATA → next state IDLE. In that cycle `data_we`, `data_re` and `rdy` are forced to 0, and the beat is neither written nor counted.
- **Strobe sources**: `data_we`, `data_re` and the write-side `rdy` are decoded from the registered state, gated only by `ack`.

## Timing

- **Reset values**: state IDLE; `bus_out`=0, `bus_oe`=0, `rdy`=0, `local_addr`=0, `data_we`=0, `data_re`=0. Reset mid-transaction takes effect immediately, with no partial strobe after `rst` rises.
- **Request-to-first-strobe latency**: `WAIT_CYCLES`+1 cycles after the IDLE cycle that sampled `ack`.
- **Beat spacing**: `WAIT_CYCLES`+1 cycles.
- **Write data**: the master presents beat k on `bus_in` during the k-th DATA cycle (`rdy`=1) and may change it on the following cycle.
- **Read data**: beat k is valid on `bus_out` from the cycle after the k-th DATA cycle until the next capture or IDLE.
- **Back-to-back**: a new transaction needs at least one IDLE cycle with `ack`=0 in between.
- **Ignored fields**: `ctrl_in` and the upper address bits are ignored outside the IDLE accept cycle.

## Test plan

- **Single write**, default params, `bus_in`=32'h0001_0010, we=1, beats−1=0, `ack` asserted at T0:
  - T1 WAIT;
  - T2 `data_we`=`rdy`=1, `local_addr`=16'h0010, `local_wdata`=data;
  - T3 FINISH;
  - IDLE the cycle after `ack` drops; `bus_oe` stays 0.
- **Burst read**, beats−1=3, `WAIT_CYCLES`=0, `local_rdata`=offset+100:
  - `data_re` high for 4 consecutive cycles at offsets 0x20..0x23;
  - `bus_out` = 0x84..0x87 in the following cycles, `rdy` high 4 cycles;
  - `bus_oe` high until IDLE.
- **Address miss**, `bus_in`=32'h0002_0000 with `ack` held 5 cycles:
  - IGNORE, no strobes, no `bus_oe`;
  - a later matching request after `ack`=0 is accepted.
- **Offset wrap**: offset 16'hFFFF with beats−1=1 → second beat at `local_addr`=16'h0000.
- **Abort**: `ack` dropped during the first WAIT of a 4-beat write → zero `data_we` pulses, IDLE next cycle, next request accepted normally.
- **Reset mid-burst**: `rst` pulsed during the second read beat → all outputs 0 immediately, state IDLE, `bus_oe` deasserted without a clock edge.

Source files
------------

// File: rtl/acp_slave_interface.sv
// acp_slave_interface
//   ACP bus slave port. It decodes a request against BASE_ADDR and handles
//   read and write transactions, including incrementing bursts of up to
//   2^BURST_BITS beats. Each data beat is preceded by WAIT_CYCLES wait states.
//   Toward the peripheral it drives a local register/memory port.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   bus_in        address in the request cycle, write data in DATA cycles
//   ctrl_in       [1] we, [2+:BURST_BITS] beats-1, other bits ignored
//   ack           master request, held high for the whole transaction
//   bus_out       registered read data
//   bus_oe        slave drives bus_out (reads only, until IDLE)
//   rdy           beat strobe toward the master
//   local_addr    current beat offset (registered)
//   local_wdata   write data (bus_in pass-through)
//   data_we       local write strobe, one cycle per beat
//   data_re       local read strobe, one cycle per beat
//   local_rdata   combinational read data, valid while data_re=1
module acp_slave_interface #(
   parameter int BUS_WIDTH   = 32,
   parameter int CTRL_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 16,
   parameter logic [BUS_WIDTH-ADDR_WIDTH-1:0] BASE_ADDR = 16'h0001,
   parameter int WAIT_CYCLES = 1,
   parameter int BURST_BITS  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BUS_WIDTH-1:0]  bus_in,
   input  logic [CTRL_WIDTH-1:0] ctrl_in,
   input  logic                  ack,
   output logic [BUS_WIDTH-1:0]  bus_out,
   output logic                  bus_oe,
   output logic                  rdy,
   output logic [ADDR_WIDTH-1:0] local_addr,
   output logic [BUS_WIDTH-1:0]  local_wdata,
   output logic                  data_we,
   output logic                  data_re,
   input  logic [BUS_WIDTH-1:0]  local_rdata
);

   localparam int WCW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [WCW-1:0] WAIT_LOAD = WCW'(WAIT_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_IGNORE, S_WAIT, S_DATA, S_FINISH} state_t;

   state_t                state, nxt;
   logic                  we_r;
   logic [BURST_BITS-1:0] beats_r;
   logic [WCW-1:0]        wcnt;
   logic                  rdy_rd;   // read-side rdy: the cycle new bus_out is visible
   logic                  hit;
   logic                  ctrl_unused;

   assign hit         = (bus_in[BUS_WIDTH-1:ADDR_WIDTH] == BASE_ADDR);
   assign local_wdata = bus_in;
   assign ctrl_unused = ^ctrl_in;

   // Next state and strobes. Strobes come only from the registered state
   // and ack, so an abort (ack=0) cycle never writes or reads.
   always_comb begin
      nxt     = state;
      data_we = 1'b0;
      data_re = 1'b0;
      rdy     = rdy_rd;
      case (state)
         S_IDLE: begin
            if (ack) begin
               if (!hit)                 nxt = S_IGNORE;
               else if (WAIT_CYCLES == 0) nxt = S_DATA;
               else                       nxt = S_WAIT;
            end
         end
         S_IGNORE: begin
            if (!ack) nxt = S_IDLE;
         end
         S_WAIT: begin
            if (!ack)                   nxt = S_IDLE;
            else if (wcnt == WCW'(1))   nxt = S_DATA;
         end
         S_DATA: begin
            if (!ack) begin
               nxt = S_IDLE;
            end else begin
               data_we = we_r;
               data_re = !we_r;
               if (we_r) rdy = 1'b1;
               if (beats_r == '0)          nxt = S_FINISH;
               else if (WAIT_CYCLES == 0)  nxt = S_DATA;
               else                        nxt = S_WAIT;
            end
         end
         S_FINISH: begin
            if (!ack) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         we_r       <= 1'b0;
         beats_r    <= '0;
         wcnt       <= '0;
         local_addr <= '0;
         bus_out    <= '0;
         bus_oe     <= 1'b0;
         rdy_rd     <= 1'b0;
      end else begin
         state  <= nxt;
         rdy_rd <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ack && hit) begin
                  we_r       <= ctrl_in[1];
                  beats_r    <= ctrl_in[2 +: BURST_BITS];
                  local_addr <= bus_in[ADDR_WIDTH-1:0];
                  wcnt       <= WAIT_LOAD;
               end
            end
            S_WAIT: begin
               if (ack) wcnt <= wcnt - WCW'(1);
            end
            S_DATA: begin
               if (ack) begin
                  if (!we_r) begin
                     bus_out <= local_rdata;
                     bus_oe  <= 1'b1;
                     rdy_rd  <= 1'b1;
                  end
                  if (beats_r != '0) begin
                     // Offset wraps naturally modulo 2^ADDR_WIDTH.
                     local_addr <= local_addr + ADDR_WIDTH'(1);
                     beats_r    <= beats_r - BURST_BITS'(1);
                     wcnt       <= WAIT_LOAD;
                  end
               end
            end
            default: ;
         endcase
         // bus_oe is released whenever we fall back to IDLE, including aborts.
         if (nxt == S_IDLE) bus_oe <= 1'b0;
      end
   end

endmodule

// File: tb/tb_acp_slave_interface.sv
module tb_acp_slave_interface;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] bus_in;
   logic [7:0]  ctrl_in;
   logic        ack;

   // dut0: default parameters (WAIT_CYCLES=1)
   logic [31:0] bus_out0, wdata0, rdata0;
   logic [15:0] addr0;
   logic        oe0, rdy0, we0, re0;
   // dut1: WAIT_CYCLES=0
   logic [31:0] bus_out1, wdata1, rdata1;
   logic [15:0] addr1;
   logic        oe1, rdy1, we1, re1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign rdata0 = 32'(addr0) + 32'd100;
   assign rdata1 = 32'(addr1) + 32'd100;

   acp_slave_interface dut0 (
      .clk(clk), .rst(rst), .bus_in(bus_in), .ctrl_in(ctrl_in), .ack(ack),
      .bus_out(bus_out0), .bus_oe(oe0), .rdy(rdy0), .local_addr(addr0),
      .local_wdata(wdata0), .data_we(we0), .data_re(re0), .local_rdata(rdata0));

   acp_slave_interface #(.WAIT_CYCLES(0)) dut1 (
      .clk(clk), .rst(rst), .bus_in(bus_in), .ctrl_in(ctrl_in), .ack(ack),
      .bus_out(bus_out1), .bus_oe(oe1), .rdy(rdy1), .local_addr(addr1),
      .local_wdata(wdata1), .data_we(we1), .data_re(re1), .local_rdata(rdata1));

   typedef struct {
      logic        ack;
      logic [31:0] din;
      logic [7:0]  ctrl;
      logic        we, re, rdy, oe;
      logic        chk_addr;
      logic [15:0] addr;
      logic        chk_out;
      logic [31:0] dout;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t v(logic a, logic [31:0] d, logic [7:0] c,
                              logic w, logic r, logic y, logic o,
                              logic ca, logic [15:0] ad, logic co, logic [31:0] dq);
      vec_t t;
      t.ack = a; t.din = d; t.ctrl = c; t.we = w; t.re = r; t.rdy = y; t.oe = o;
      t.chk_addr = ca; t.addr = ad; t.chk_out = co; t.dout = dq;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive just after the edge, sample mid-cycle.
   task automatic step(input logic a, input logic [31:0] d, input logic [7:0] c);
      @(posedge clk);
      #1;
      ack = a; bus_in = d; ctrl_in = c;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; ack = 1'b0; bus_in = '0; ctrl_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_we",   32'(we0),  0);
      chk("rst_re",   32'(re0),  0);
      chk("rst_rdy",  32'(rdy0), 0);
      chk("rst_oe",   32'(oe0),  0);
      chk("rst_addr", 32'(addr0), 0);
      chk("rst_out",  bus_out0,  0);
      @(posedge clk); #1 rst = 1'b0;

      // ---- table on dut0 (WAIT_CYCLES=1) ----
      // single write
      vt.push_back(v(1, 32'h0001_0010, 8'h02, 0,0,0,0, 1,16'h0000, 1,0));
      vt.push_back(v(1, 32'hDEAD_BEEF, 8'h00, 0,0,0,0, 1,16'h0010, 0,0));
      vt.push_back(v(1, 32'hDEAD_BEEF, 8'h00, 1,0,1,0, 1,16'h0010, 0,0));
      vt.push_back(v(1, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0010, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0010, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0010, 0,0));
      // two-beat write
      vt.push_back(v(1, 32'h0001_0123, 8'h06, 0,0,0,0, 1,16'h0010, 0,0));
      vt.push_back(v(1, 32'h1111_1111, 8'h00, 0,0,0,0, 1,16'h0123, 0,0));
      vt.push_back(v(1, 32'h1111_1111, 8'h00, 1,0,1,0, 1,16'h0123, 0,0));
      vt.push_back(v(1, 32'h2222_2222, 8'h00, 0,0,0,0, 1,16'h0124, 0,0));
      vt.push_back(v(1, 32'h2222_2222, 8'h00, 1,0,1,0, 1,16'h0124, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0124, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0124, 0,0));
      // address miss, ack held 5 cycles; a matching address mid-hold is not re-decoded
      vt.push_back(v(1, 32'h0002_0000, 8'h02, 0,0,0,0, 1,16'h0124, 0,0));
      vt.push_back(v(1, 32'h0002_0000, 8'h02, 0,0,0,0, 1,16'h0124, 0,0));
      vt.push_back(v(1, 32'h0001_0000, 8'h02, 0,0,0,0, 1,16'h0124, 0,0));
      vt.push_back(v(1, 32'h0001_0000, 8'h02, 0,0,0,0, 1,16'h0124, 0,0));
      vt.push_back(v(1, 32'h0001_0000, 8'h02, 0,0,0,0, 1,16'h0124, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0124, 0,0));
      vt.push_back(v(1, 32'h0001_0040, 8'h02, 0,0,0,0, 1,16'h0124, 0,0));
      vt.push_back(v(1, 32'h5555_AAAA, 8'h00, 0,0,0,0, 1,16'h0040, 0,0));
      vt.push_back(v(1, 32'h5555_AAAA, 8'h00, 1,0,1,0, 1,16'h0040, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0040, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0040, 0,0));
      // single read at 0x50: local_rdata = 0x50+100 = 0xB4
      vt.push_back(v(1, 32'h0001_0050, 8'h00, 0,0,0,0, 1,16'h0040, 1,0));
      vt.push_back(v(1, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0050, 1,0));
      vt.push_back(v(1, 32'h0000_0000, 8'h00, 0,1,0,0, 1,16'h0050, 1,0));
      vt.push_back(v(1, 32'h0000_0000, 8'h00, 0,0,1,1, 1,16'h0050, 1,32'hB4));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,1, 1,16'h0050, 1,32'hB4));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0050, 0,0));
      // abort in first WAIT of a 4-beat write; next request taken at once
      vt.push_back(v(1, 32'h0001_0060, 8'h0E, 0,0,0,0, 1,16'h0050, 0,0));
      vt.push_back(v(0, 32'h0001_0060, 8'h0E, 0,0,0,0, 1,16'h0060, 0,0));
      vt.push_back(v(1, 32'h0001_0070, 8'h02, 0,0,0,0, 1,16'h0060, 0,0));
      vt.push_back(v(1, 32'h7777_0000, 8'h00, 0,0,0,0, 1,16'h0070, 0,0));
      vt.push_back(v(1, 32'h7777_0000, 8'h00, 1,0,1,0, 1,16'h0070, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0070, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0070, 0,0));
      // offset wrap FFFF -> 0000
      vt.push_back(v(1, 32'h0001_FFFF, 8'h06, 0,0,0,0, 1,16'h0070, 0,0));
      vt.push_back(v(1, 32'h0000_000A, 8'h00, 0,0,0,0, 1,16'hFFFF, 0,0));
      vt.push_back(v(1, 32'h0000_000A, 8'h00, 1,0,1,0, 1,16'hFFFF, 0,0));
      vt.push_back(v(1, 32'h0000_000B, 8'h00, 0,0,0,0, 1,16'h0000, 0,0));
      vt.push_back(v(1, 32'h0000_000B, 8'h00, 1,0,1,0, 1,16'h0000, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0000, 0,0));
      vt.push_back(v(0, 32'h0000_0000, 8'h00, 0,0,0,0, 1,16'h0000, 0,0));

      foreach (vt[i]) begin
         step(vt[i].ack, vt[i].din, vt[i].ctrl);
         chk($sformatf("v%0d_we", i),  32'(we0),  32'(vt[i].we));
         chk($sformatf("v%0d_re", i),  32'(re0),  32'(vt[i].re));
         chk($sformatf("v%0d_rdy", i), 32'(rdy0), 32'(vt[i].rdy));
         chk($sformatf("v%0d_oe", i),  32'(oe0),  32'(vt[i].oe));
         if (vt[i].chk_addr) chk($sformatf("v%0d_addr", i), 32'(addr0), 32'(vt[i].addr));
         if (vt[i].chk_out)  chk($sformatf("v%0d_out", i), bus_out0, vt[i].dout);
         if (vt[i].we)       chk($sformatf("v%0d_wdata", i), wdata0, vt[i].din);
      end

      // ---- burst read on dut1 (WAIT_CYCLES=0), offsets 0x20..0x23 ----
      step(0, 32'h0, 8'h00);
      step(1, 32'h0001_0020, 8'h0C);
      chk("br_idle_re", 32'(re1), 0);
      for (int k = 0; k < 4; k++) begin
         step(1, 32'h0, 8'h00);
         chk($sformatf("br%0d_re", k),   32'(re1),  1);
         chk($sformatf("br%0d_addr", k), 32'(addr1), 32'h20 + 32'(k));
         chk($sformatf("br%0d_rdy", k),  32'(rdy1), (k == 0) ? 0 : 1);
         chk($sformatf("br%0d_oe", k),   32'(oe1),  (k == 0) ? 0 : 1);
         if (k > 0) chk($sformatf("br%0d_out", k), bus_out1, 32'h84 + 32'(k) - 1);
      end
      step(1, 32'h0, 8'h00);
      chk("br_fin_re",  32'(re1),  0);
      chk("br_fin_rdy", 32'(rdy1), 1);
      chk("br_fin_out", bus_out1,  32'h87);
      chk("br_fin_oe",  32'(oe1),  1);
      step(0, 32'h0, 8'h00);
      chk("br_drop_rdy", 32'(rdy1), 0);
      chk("br_drop_oe",  32'(oe1),  1);
      step(0, 32'h0, 8'h00);
      chk("br_idle_oe",  32'(oe1),  0);

      // ---- reset during second read beat of a dut1 burst ----
      step(1, 32'h0001_0030, 8'h0C);
      step(1, 32'h0, 8'h00);
      step(1, 32'h0, 8'h00);
      chk("rm_re_before", 32'(re1), 1);
      chk("rm_oe_before", 32'(oe1), 1);
      #2 rst = 1'b1;
      #1;
      chk("rm_re",   32'(re1),   0);
      chk("rm_rdy",  32'(rdy1),  0);
      chk("rm_oe",   32'(oe1),   0);
      chk("rm_addr", 32'(addr1), 0);
      chk("rm_out",  bus_out1,   0);
      ack = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      step(0, 32'h0, 8'h00);
      step(1, 32'h0001_0038, 8'h00);
      chk("rm_after_idle_re", 32'(re1), 0);
      step(1, 32'h0, 8'h00);
      chk("rm_after_re",   32'(re1),   1);
      chk("rm_after_addr", 32'(addr1), 32'h38);
      step(0, 32'h0, 8'h00);
      step(0, 32'h0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
